seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
// - Multi-cycle restoring divider for MIPS DIV/DIVU. It produces the quotient (LO) and remainder (HI) from one dividend/divisor pair.
// - It is the inverse-operation companion to the combinational multiplier in the execute stage.
// - The control unit stalls on busy and writes HI/LO on the done pulse.
// PARAMETERS
// - WIDTH   32   operand/result width in bits; must be >= 2
// - CNT_W    6   iteration counter width; must satisfy 2^CNT_W > WIDTH
// PORTS
// - clk          in   1      single clock; all state changes on the rising edge
// - rst          in   1      asynchronous, active-high reset
// - start        in   1      request a division; sampled only in IDLE
// - is_signed    in   1      1 = DIV (two's complement), 0 = DIVU
// - dividend     in   WIDTH  numerator; captured on the accepted start
// - divisor      in   WIDTH  denominator; captured on the accepted start
// - busy         out  1      high while an operation is in flight (RUN or FIX)
// - done         out  1      one-cycle pulse; results valid from this cycle on
// - quotient     out  WIDTH  LO result; held until the next done
// - remainder    out  WIDTH  HI result; held until the next done
// - div_by_zero  out  1      flag for the last completed op; held with the results
// BEHAVIOUR
// - Clock and reset: one clock; reset is asynchronous and active-high.
// - Reset values: state=IDLE; busy, done, div_by_zero, quotient and remainder are all 0.
// - Reset asserted mid-operation aborts it immediately. No done pulse is produced.
// - FSM IDLE: if start=1, capture operands, the sign flags and the magnitudes, clear the partial remainder, set cnt=0, then go to RUN.
// - FSM RUN: one restoring step per cycle.
//   - Shift {rem,quo} left by 1; trial = rem - |divisor|.
//   - If trial >= 0: rem = trial and quo[0] = 1; otherwise quo[0] = 0.
//   - After WIDTH steps, go to FIX.
// - FSM FIX: apply the sign correction, load quotient/remainder, pulse done=1 for this cycle only, go to IDLE.
// - Latency: start sampled at edge E0; busy=1 after E0 through E(WIDTH+1); done=1 after E(WIDTH+1), i.e. 33 edges for WIDTH=32.
// - Back-to-back: start may be asserted in the cycle done is high. The FSM is in IDLE then, so the new op is accepted on that edge.
// - start while busy=1 is ignored. It is not queued, and there is no error.
// - Operand inputs are don't-care after the accepting edge.
// - Signed rules:
//   - Compute on magnitudes, truncating toward zero.
//   - quotient is negated iff the operand signs differ.
//   - remainder takes the sign of the dividend.
//   - The magnitude of the minimum negative value is taken as unsigned 2^(WIDTH-1). No overflow trap.
// - Overflow case: MIN_INT / -1 gives quotient = MIN_INT and remainder = 0. The natural wrap is the required result.
// - Divide by zero (divisor == 0, either mode):
//   - Same latency as a normal op.
//   - Result: quotient = all ones, remainder = dividend unchanged, div_by_zero = 1.
// - div_by_zero is 0 for every other completed op.
// - quotient, remainder and div_by_zero update only in FIX. They are stable at all other times.
// STRUCTURE
// - Shared header mips_defs.vh:
//   - DIV_IDLE/DIV_RUN/DIV_FIX state localparams (2-bit encoding)
//   - the WIDTH default shared with the multiplier
// - A single-step sub-module div_step is natural.
//   - It is combinational: {rem,quo},|divisor| in -> next {rem,quo} out.
//   - seq_divider instantiates it once and holds the FSM, the counter and the sign logic.
// - All outputs come straight from registers. No combinational path from inputs to outputs.
// TESTING
// - DIVU 100/7 -> done after 33 edges; quotient=14, remainder=2, div_by_zero=0; busy high 33 cycles.
// - DIV -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
// - DIV 7/-2 -> quotient=-3, remainder=1.
// - DIVU 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
// - DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
// - DIV 0x1234/0 -> quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
// - Start 50/5; pulse start with 9/3 at cycle 10 (ignored); assert start=9/3 during done
//   -> first result is 10/0 with no second done until 33 edges later; second result is 3/0.
// - Start 1000/3; assert rst at cycle 15 -> busy=0, done never pulses, outputs 0; a new 1000/3 returns 333/1.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential MIPS DIV/DIVU unit.
// Holds the default operand width (shared with the multiplier), the
// iteration counter width and the 2-bit FSM state encoding.
package seq_divider_pkg;

  // Operand/result width shared with the execute-stage multiplier
  localparam int unsigned DIV_WIDTH = 32;

  // Iteration counter width; 2**DIV_CNT_W must exceed DIV_WIDTH
  localparam int unsigned DIV_CNT_W = 6;

  // FSM state encoding
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_in, quo_in  partial remainder / quotient-dividend shift register
//   dvs             divisor magnitude
//   rem_out, quo_out  state after shifting left by one and a trial subtract
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic           ge;

  // Shifted remainder needs one extra bit so the trial compare is exact
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    ge      = (shifted >= {1'b0, dvs});
    rem_out = ge ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for MIPS DIV (signed) and DIVU (unsigned).
// Produces quotient (LO) and remainder (HI); WIDTH steps plus one fix-up
// cycle per operation. All outputs are registered.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            request a division (sampled only when idle)
//   is_signed        1 = DIV, 0 = DIVU
//   dividend/divisor operands, captured on the accepted start
//   busy             operation in flight
//   done             one-cycle pulse when results update
//   quotient/remainder/div_by_zero  results of the last completed op
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dividend_raw;
  logic             neg_quo;
  logic             neg_rem;
  logic             dvs_zero;

  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH-1:0] step_rem_c;
  logic [WIDTH-1:0] step_quo_c;

  // Operand magnitudes; MIN_INT maps to unsigned 2**(WIDTH-1) naturally
  always_comb begin
    a_neg_c = is_signed & dividend[WIDTH-1];
    b_neg_c = is_signed & divisor[WIDTH-1];
    a_mag_c = a_neg_c ? (WIDTH'(0) - dividend) : dividend;
    b_mag_c = b_neg_c ? (WIDTH'(0) - divisor) : divisor;
  end

  seq_divider_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .dvs     (dvs_mag),
    .rem_out (step_rem_c),
    .quo_out (step_quo_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (start) state_next = DIV_RUN;
      DIV_RUN:  if (cnt == CNT_W'(WIDTH - 1)) state_next = DIV_FIX;
      DIV_FIX:  state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_mag      <= '0;
      dividend_raw <= '0;
      neg_quo      <= 1'b0;
      neg_rem      <= 1'b0;
      dvs_zero     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
    end else begin
      busy <= (state_next != DIV_IDLE);
      done <= (state == DIV_FIX);
      case (state)
        DIV_IDLE: begin
          if (start) begin
            cnt          <= '0;
            rem_q        <= '0;
            quo_q        <= a_mag_c;
            dvs_mag      <= b_mag_c;
            dividend_raw <= dividend;
            neg_quo      <= a_neg_c ^ b_neg_c;
            neg_rem      <= a_neg_c;
            dvs_zero     <= (divisor == '0);
          end
        end
        DIV_RUN: begin
          rem_q <= step_rem_c;
          quo_q <= step_quo_c;
          cnt   <= cnt + CNT_W'(1);
        end
        DIV_FIX: begin
          // Zero divisor overrides the sign fix: all-ones / dividend as given
          if (dvs_zero) begin
            quotient  <= '1;
            remainder <= dividend_raw;
          end else begin
            quotient  <= neg_quo ? (WIDTH'(0) - quo_q) : quo_q;
            remainder <= neg_rem ? (WIDTH'(0) - rem_q) : rem_q;
          end
          div_by_zero <= dvs_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=q:%h r:%h required=no_done", quotient, remainder);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
      end
    end
  end

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Count edges until done is seen; bounded
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcnt++;
    end while (!done && lat < 60);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d required=done", lat);
    end
  endtask

  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] q, input logic [31:0] r, input logic z);
    exp_t e;
    int   lat;
    int   bc;
    e.q = q; e.r = r; e.z = z;
    sb.push_back(e);
    issue(s, a, b);
    wait_done(lat, bc);
    chk("latency", 32'(lat), 32'd33);
  endtask

  initial begin
    exp_t e;
    int   lat;
    int   bc;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // DIVU 100/7 with latency and busy-length checks
    e.q = 32'd14; e.r = 32'd2; e.z = 1'b0;
    sb.push_back(e);
    issue(1'b0, 32'd100, 32'd7);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done(lat, bc);
    chk("latency_100_7", 32'(lat), 32'd33);
    chk("busy_cycles", 32'(bc + 1), 32'd33);
    chk("busy_at_done", 32'(busy), 32'd0);

    run(1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run(1'b1, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,         1'b0);
    run(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 1'b0);
    run(1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'd0,         1'b0);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0);
    run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 1'b0);
    run(1'b1, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
    run(1'b0, 32'd5,         32'd0,          32'hFFFF_FFFF, 32'd5,         1'b1);

    // 50/5, ignored start mid-run, then back-to-back 9/3 during done
    e.q = 32'd10; e.r = 32'd0; e.z = 1'b0;
    sb.push_back(e);
    issue(1'b0, 32'd50, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bc);
    chk("latency_with_ignored_start", 32'(lat), 32'd23);
    e.q = 32'd3; e.r = 32'd0; e.z = 1'b0;
    sb.push_back(e);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_accepted_busy", 32'(busy), 32'd1);
    wait_done(lat, bc);
    chk("latency_b2b", 32'(lat), 32'd33);

    // Reset aborts an op in flight
    issue(1'b0, 32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("idle_after_abort", 32'(busy), 32'd0);
    run(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
